// File: rtl/pulpemu_ctrl.sv
// PULP SoC emulation controller: sequences SoC reset/fetch-enable from PS
// commands and reports end-of-computation or timeout back to the PS.
module pulpemu_ctrl #(
    parameter int GPIO_W   = 32,
    parameter int LED_W    = 8,
    parameter int RST_HOLD = 16,
    parameter int EOC_BIT  = 0
) (
    input  logic              ps7_clk,
    input  logic              ps7_rst_n,
    input  logic [31:0]       ps_ctrl_i,
    input  logic [31:0]       ps_timeout_i,
    input  logic [GPIO_W-1:0] soc_gpio_i,
    output logic              soc_rst_no,
    output logic              fetch_en_o,
    output logic              jtag_sel_o,
    output logic [LED_W-1:0]  led_o,
    output logic [31:0]       status_o,
    output logic [31:0]       cycles_o,
    output logic [GPIO_W-1:0] result_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RST  = 3'd1,
        RUN  = 3'd2,
        DONE = 3'd3,
        TOUT = 3'd4
    } state_t;

    state_t            state;
    logic [GPIO_W-1:0] gpio_s1;
    logic [GPIO_W-1:0] gpio_s2;
    logic [2:0]        ctrl_q;
    logic [1:0]        edge_q;
    logic              primed;
    logic [7:0]        hold;
    logic              done;
    logic              tout;
    logic              start_edge;
    logic              abort_edge;
    logic              eoc;
    logic [31:0]       cyc_inc;
    logic              unused_ctrl;

    assign unused_ctrl = ^ps_ctrl_i[31:3];

    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            gpio_s1 <= '0;
            gpio_s2 <= '0;
        end else begin
            gpio_s1 <= soc_gpio_i;
            gpio_s2 <= gpio_s1;
        end
    end

    // First cycle after reset loads both stages so a held level is not an edge
    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            ctrl_q <= '0;
            edge_q <= '0;
            primed <= 1'b0;
        end else begin
            ctrl_q <= ps_ctrl_i[2:0];
            primed <= 1'b1;
            if (!primed) begin
                edge_q <= ps_ctrl_i[1:0];
            end else begin
                edge_q <= ctrl_q[1:0];
            end
        end
    end

    assign start_edge = primed & ctrl_q[0] & ~edge_q[0];
    assign abort_edge = primed & ctrl_q[1] & ~edge_q[1];
    assign eoc        = gpio_s2[EOC_BIT];
    assign cyc_inc    = cycles_o + 32'd1;
    assign jtag_sel_o = ctrl_q[2];
    assign led_o      = gpio_s2[8 +: LED_W];
    assign status_o   = {27'd0, tout, done, state};

    always_ff @(posedge ps7_clk or negedge ps7_rst_n) begin
        if (!ps7_rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            done       <= 1'b0;
            tout       <= 1'b0;
            soc_rst_no <= 1'b0;
            fetch_en_o <= 1'b0;
            cycles_o   <= '0;
            result_o   <= '0;
        end else begin
            if (state == RUN && cycles_o != 32'hFFFF_FFFF) begin
                cycles_o <= cyc_inc;
            end
            if (abort_edge) begin
                state      <= IDLE;
                soc_rst_no <= 1'b0;
                fetch_en_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE, TOUT: begin
                        if (start_edge) begin
                            state      <= RST;
                            hold       <= '0;
                            done       <= 1'b0;
                            tout       <= 1'b0;
                            cycles_o   <= '0;
                            result_o   <= '0;
                            soc_rst_no <= 1'b0;
                            fetch_en_o <= 1'b0;
                        end
                    end
                    RST: begin
                        if (hold == 8'(RST_HOLD - 1)) begin
                            state      <= RUN;
                            soc_rst_no <= 1'b1;
                        end else begin
                            hold <= hold + 8'd1;
                        end
                    end
                    RUN: begin
                        if (eoc) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            result_o   <= gpio_s2;
                            fetch_en_o <= 1'b0;
                        end else if (ps_timeout_i != '0 &&
                                     cyc_inc == ps_timeout_i) begin
                            state      <= TOUT;
                            tout       <= 1'b1;
                            result_o   <= gpio_s2;
                            fetch_en_o <= 1'b0;
                        end else begin
                            fetch_en_o <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        soc_rst_no <= 1'b0;
                        fetch_en_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulpemu_ctrl.sv
// Directed scoreboard bench for pulpemu_ctrl: expectations are queued when
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_pulpemu_ctrl;

    logic        ps7_clk = 1'b0;
    logic        ps7_rst_n;
    logic [31:0] ps_ctrl_i;
    logic [31:0] ps_timeout_i;
    logic [31:0] soc_gpio_i;
    logic        soc_rst_no;
    logic        fetch_en_o;
    logic        jtag_sel_o;
    logic [7:0]  led_o;
    logic [31:0] status_o;
    logic [31:0] cycles_o;
    logic [31:0] result_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    pulpemu_ctrl dut (
        .ps7_clk      (ps7_clk),
        .ps7_rst_n    (ps7_rst_n),
        .ps_ctrl_i    (ps_ctrl_i),
        .ps_timeout_i (ps_timeout_i),
        .soc_gpio_i   (soc_gpio_i),
        .soc_rst_no   (soc_rst_no),
        .fetch_en_o   (fetch_en_o),
        .jtag_sel_o   (jtag_sel_o),
        .led_o        (led_o),
        .status_o     (status_o),
        .cycles_o     (cycles_o),
        .result_o     (result_o)
    );

    always #5 ps7_clk = ~ps7_clk;

    task automatic push(input string t, input logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%h expected=<entry>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ps7_clk);
    endtask

    task automatic pulse(input logic [31:0] v);
        ps_ctrl_i = v;
        tick(1);
        ps_ctrl_i = 32'h0;
        tick(1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int max,
                              input string tag);
        int i = 0;
        while (status_o[2:0] !== s && i < max) begin
            tick(1);
            i++;
        end
        push(tag, {29'd0, s});
        pop_chk({29'd0, status_o[2:0]});
    endtask

    task automatic wait_cycles(input logic [31:0] c, input int max,
                               input string tag);
        int i = 0;
        while (cycles_o !== c && i < max) begin
            tick(1);
            i++;
        end
        push(tag, c);
        pop_chk(cycles_o);
    endtask

    initial begin
        int cnt;
        ps7_rst_n    = 1'b0;
        ps_ctrl_i    = 32'h0;
        ps_timeout_i = 32'h0;
        soc_gpio_i   = 32'h0;
        tick(3);
        push("rst_status", 32'h0);
        push("rst_soc_rst", 32'h0);
        push("rst_fetch", 32'h0);
        push("rst_cycles", 32'h0);
        push("rst_result", 32'h0);
        push("rst_led", 32'h0);
        push("rst_jtag", 32'h0);
        pop_chk(status_o);
        pop_chk({31'd0, soc_rst_no});
        pop_chk({31'd0, fetch_en_o});
        pop_chk(cycles_o);
        pop_chk(result_o);
        pop_chk({24'd0, led_o});
        pop_chk({31'd0, jtag_sel_o});
        ps7_rst_n = 1'b1;
        tick(3);

        // start, no timeout: RST hold then RUN
        pulse(32'h1);
        push("t1_rst_state", 32'h1);
        push("t1_rst_soc", 32'h0);
        pop_chk(status_o);
        pop_chk({31'd0, soc_rst_no});
        cnt = 0;
        while (status_o[2:0] == 3'd1 && cnt < 100) begin
            tick(1);
            cnt++;
        end
        push("t1_rst_len", 32'd16);
        push("t1_run_state", 32'h2);
        push("t1_run_soc", 32'h1);
        push("t1_run_fetch0", 32'h0);
        pop_chk(cnt);
        pop_chk(status_o);
        pop_chk({31'd0, soc_rst_no});
        pop_chk({31'd0, fetch_en_o});
        tick(1);
        push("t1_fetch1", 32'h1);
        push("t1_cycles1", 32'd1);
        pop_chk({31'd0, fetch_en_o});
        pop_chk(cycles_o);

        // EOC with LED pattern after 100 run cycles
        tick(99);
        push("t2_cycles100", 32'd100);
        pop_chk(cycles_o);
        soc_gpio_i = 32'h0000_A501;
        push("t2_led", 32'hA5);
        push("t2_still_run", 32'h2);
        push("t2_status", 32'h0B);
        push("t2_result_hi", 32'hA5);
        push("t2_fetch", 32'h0);
        push("t2_cycles", 32'd103);
        tick(2);
        pop_chk({24'd0, led_o});
        pop_chk(status_o);
        tick(1);
        pop_chk(status_o);
        pop_chk({24'd0, result_o[15:8]});
        pop_chk({31'd0, fetch_en_o});
        pop_chk(cycles_o);

        // timeout of 50 without EOC
        soc_gpio_i   = 32'h0;
        ps_timeout_i = 32'd50;
        tick(3);
        pulse(32'h1);
        push("t3_restart", 32'h1);
        push("t3_cyc_clr", 32'h0);
        push("t3_res_clr", 32'h0);
        pop_chk(status_o);
        pop_chk(cycles_o);
        pop_chk(result_o);
        wait_state(3'd2, 40, "t3_run");
        wait_state(3'd4, 100, "t3_tout");
        push("t3_status", 32'h14);
        push("t3_cycles", 32'd50);
        push("t3_fetch", 32'h0);
        pop_chk(status_o);
        pop_chk(cycles_o);
        pop_chk({31'd0, fetch_en_o});

        // EOC lands in the timeout cycle: EOC wins
        ps_timeout_i = 32'd30;
        pulse(32'h1);
        wait_state(3'd2, 40, "t4_run");
        wait_cycles(32'd27, 100, "t4_cyc27");
        soc_gpio_i = 32'h1;
        push("t4_pre_state", 32'h2);
        push("t4_pre_cycles", 32'd29);
        push("t4_status", 32'h0B);
        push("t4_cycles", 32'd30);
        tick(2);
        pop_chk(status_o);
        pop_chk(cycles_o);
        tick(1);
        pop_chk(status_o);
        pop_chk(cycles_o);

        // abort + start together during RUN
        soc_gpio_i   = 32'h0;
        ps_timeout_i = 32'h0;
        tick(3);
        pulse(32'h1);
        wait_state(3'd2, 40, "t5_run");
        wait_cycles(32'd20, 100, "t5_cyc20");
        pulse(32'h3);
        push("t5_idle", 32'h0);
        push("t5_soc", 32'h0);
        push("t5_fetch", 32'h0);
        push("t5_cycles", 32'd22);
        push("t5_cyc_keep", 32'd22);
        push("t5_res_keep", 32'h0);
        push("t5_restart", 32'h1);
        push("t5_cyc_clr", 32'h0);
        pop_chk(status_o);
        pop_chk({31'd0, soc_rst_no});
        pop_chk({31'd0, fetch_en_o});
        pop_chk(cycles_o);
        tick(5);
        pop_chk(cycles_o);
        pop_chk(result_o);
        pulse(32'h1);
        pop_chk(status_o);
        pop_chk(cycles_o);

        // async reset mid-RUN with start held high
        soc_gpio_i = 32'h0000_3C00;
        ps_ctrl_i  = 32'h4;
        wait_state(3'd2, 40, "t6_run");
        tick(10);
        ps_ctrl_i = 32'h5;
        tick(3);
        push("t6_state", 32'h2);
        push("t6_jtag", 32'h1);
        push("t6_led", 32'h3C);
        push("t6_soc", 32'h1);
        push("t6_fetch", 32'h1);
        pop_chk(status_o);
        pop_chk({31'd0, jtag_sel_o});
        pop_chk({24'd0, led_o});
        pop_chk({31'd0, soc_rst_no});
        pop_chk({31'd0, fetch_en_o});
        #2 ps7_rst_n = 1'b0;
        #1;
        push("t6a_soc", 32'h0);
        push("t6a_fetch", 32'h0);
        push("t6a_status", 32'h0);
        push("t6a_cycles", 32'h0);
        push("t6a_jtag", 32'h0);
        push("t6a_led", 32'h0);
        push("t6a_result", 32'h0);
        pop_chk({31'd0, soc_rst_no});
        pop_chk({31'd0, fetch_en_o});
        pop_chk(status_o);
        pop_chk(cycles_o);
        pop_chk({31'd0, jtag_sel_o});
        pop_chk({24'd0, led_o});
        pop_chk(result_o);
        tick(1);
        ps7_rst_n = 1'b1;
        tick(30);
        push("t6b_status", 32'h0);
        push("t6b_soc", 32'h0);
        push("t6b_fetch", 32'h0);
        push("t6b_jtag", 32'h1);
        push("t6b_led", 32'h3C);
        pop_chk(status_o);
        pop_chk({31'd0, soc_rst_no});
        pop_chk({31'd0, fetch_en_o});
        pop_chk({31'd0, jtag_sel_o});
        pop_chk({24'd0, led_o});

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
